fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction fetch unit that succeeds the single-increment fetch block. It owns the program counter and issues sequential word fetches to a synchronous instruction memory. Returned instructions are buffered in a small prefetch queue that drains to decode under a valid/ready handshake. Branch and jump redirects from execute flush all queued and in-flight fetches and restart fetching at the target.

## Interface
Parameters:
- ADDR_W, 32: PC and memory address width.
- INST_W, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset.
- FQ_DEPTH, 4: prefetch queue entries; power of two, ≥2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  fetch address (word-aligned).
- imem_rdata  in  INST_W  instruction; valid exactly one cycle after imem_req.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  ADDR_W  redirect target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts.
- out_inst  out  INST_W  instruction at the queue head.
- out_pc  out  ADDR_W  PC of out_inst.
- fetch_fault  out  1  misaligned redirect trap; present only with the macro defined.

## Operation
- State:
  - fetch_pc: next address to request.
  - inflight: 1 bit, a request is outstanding.
  - inflight_pc: address of the outstanding request.
  - queue: FQ_DEPTH entries of {inst, pc}, with a count register.
- Request rule: imem_req = !redirect_valid && !fault && (count + inflight < FQ_DEPTH). A request is never issued without a guaranteed free slot.
- On each request:
  - imem_addr = fetch_pc.
  - fetch_pc += 4, wrapping modulo 2^ADDR_W.
  - inflight is set and inflight_pc = fetch_pc.
- Response: in the cycle after a request, if the request has not been killed, {imem_rdata, inflight_pc} is pushed into the queue at the clock edge.
- Dequeue:
  - out_valid = (count != 0) && !redirect_valid.
  - The head pops on out_valid && out_ready.
  - A push and a pop in the same cycle leave count unchanged.
- Redirect (redirect_valid = 1):
  - Queue is flushed (count = 0).
  - An outstanding response is discarded.
  - fetch_pc = redirect_pc.
  - No request and no dequeue occur that cycle.
  - Redirect overrides any simultaneous push or pop.
- Back-pressure: out_ready held low lets the queue fill to FQ_DEPTH. Requests then stop, and the head stays stable on out_inst/out_pc until it is accepted.
- Reset mid-operation:
  - Immediately clears count and inflight, and sets fetch_pc = RESET_PC.
  - Outputs go to their reset values asynchronously.

## Timing
- Reset values:
  - imem_req = 0 while reset is asserted.
  - imem_addr = RESET_PC.
  - out_valid = 0; out_inst = 0; out_pc = 0.
  - fetch_fault = 0.
- The first request (address RESET_PC) is issued in the first cycle after reset deasserts.
- Latency: a request in cycle N returns data in N+1 and produces out_valid at N+2.
- Redirect in cycle R:
  - Request to the target in R+1.
  - Target instruction on out at R+3.
- Steady state with out_ready = 1: one instruction per cycle.
- Queue pointers wrap modulo FQ_DEPTH.
- Full queue: requests stop so that count + inflight never exceeds FQ_DEPTH.
- Empty queue: out_valid = 0, and out_inst/out_pc hold their previous values.

## Configuration
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect whose redirect_pc[1:0] != 0 sets a sticky fetch_fault.
  - The fault blocks requests and keeps out_valid = 0.
  - Only the next aligned redirect or reset clears the fault, and that redirect is then executed normally.
- Undefined:
  - The fetch_fault port is absent.
  - redirect_pc[1:0] is forced to 0 before loading fetch_pc.

## Structure
- Shared package fetch_pkg holds:
  - the PC increment constant (4);
  - a typedef for the queue entry struct {inst, pc};
  - the default RESET_PC.
- One sub-module, fetch_queue: synchronous FIFO with flush, push, pop and count, parametrised by width and depth.
- fetch_unit holds the PC, inflight and request logic.

## Test plan
- Reset, then out_ready = 1 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; out_pc 0x0 at the second cycle after the first request, then one instruction per cycle.
- out_ready = 0 for 10 cycles with FQ_DEPTH = 4 -> exactly 4 requests issued, imem_req then 0, and head out_pc = 0x0 stable; releasing out_ready drains 0x0, 0x4, 0x8, 0xC in order.
- Redirect to 0x100 while the queue holds 3 entries and one is inflight -> no stale PC is ever presented; the next out_pc is 0x100, three cycles after the redirect.
- Redirect coincident with out_valid && out_ready -> no pop is counted and the queue is empty next cycle; a bench scoreboard sees no instruction from before the redirect after it.
- Redirect to 0xFFFFFFFC with ADDR_W = 32 -> fetches 0xFFFFFFFC, then 0x00000000 (wrap).
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> fetch_fault = 1, imem_req = 0, out_valid = 0; a later redirect to 0x200 clears the fault and fetch resumes at 0x200. Without the macro, the same redirect fetches 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the instruction fetch slice.
package fetch_pkg;

    // Byte distance between consecutive instruction words
    localparam int unsigned FETCH_PC_INC = 4;

    // Default widths and reset vector of the fetch path
    localparam int unsigned FETCH_ADDR_W   = 32;
    localparam int unsigned FETCH_INST_W   = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // Prefetch queue entry at the default widths: instruction plus its PC
    typedef struct packed {
        logic [FETCH_INST_W-1:0] inst;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory bus, execute redirect and decode handshake
// of the fetch unit. master = fetch unit side, slave = memory/execute/decode side.
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_inst, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_inst, out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO with flush. The head is presented
// combinationally; while empty the last presented head is held on head_data.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [WIDTH-1:0] hold;
    logic             not_empty;

    assign not_empty = (count != '0);
    assign head_data = not_empty ? mem[rd_ptr] : hold;

    // Entry storage: written on push, no reset needed for data
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush wins over a simultaneous push or pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Remember the head being shown so it stays put once the queue empties
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold <= '0;
        end else if (not_empty) begin
            hold <= mem[rd_ptr];
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues sequential word fetches to a synchronous
// instruction memory and buffers returns in a prefetch queue toward decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky misaligned-redirect
// fault and fetch_fault port); without it redirect targets are word-aligned.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
    parameter int                FQ_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.master  bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic          fetch_fault
`endif
);
    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              fault;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              req;
    logic              push;
    logic              pop;
    logic              load_redirect;
    logic [ADDR_W-1:0] redirect_target;
    entry_t            push_entry;
    entry_t            head_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic redirect_bad;

    assign redirect_bad    = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign load_redirect   = bus.redirect_valid && !redirect_bad;
    assign redirect_target = bus.redirect_pc;
    assign fetch_fault     = fault;

    // Sticky fault: set by a misaligned redirect, cleared by an aligned one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (bus.redirect_valid) begin
            fault <= redirect_bad;
        end
    end
`else
    assign load_redirect   = bus.redirect_valid;
    assign redirect_target = bus.redirect_pc & ~ADDR_W'(3);
    assign fault           = 1'b0;
`endif

    // Slots already claimed: queued entries plus the response still in flight
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign req       = !reset && !bus.redirect_valid && !fault &&
                       (occupancy < (CNT_W + 1)'(FQ_DEPTH));

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;

    // A response is dropped when a redirect lands in its return cycle
    assign push       = inflight && !bus.redirect_valid;
    assign push_entry = '{inst: bus.imem_rdata, pc: inflight_pc};

    assign bus.out_valid = (count != '0) && !bus.redirect_valid && !fault;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_inst  = head_entry.inst;
    assign bus.out_pc    = head_entry.pc;

    // ---- stage boundary: request issue -> memory response ----
    // Next-fetch PC and outstanding-request flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= req;
            if (load_redirect) begin
                fetch_pc <= redirect_target;
            end else if (req) begin
                fetch_pc <= fetch_pc + ADDR_W'(FETCH_PC_INC);
            end
        end
    end

    // PC tag travelling with the outstanding request
    always_ff @(posedge clock) begin
        if (req) begin
            inflight_pc <= fetch_pc;
        end
    end

    // ---- stage boundary: memory response -> prefetch queue -> decode ----
    fetch_queue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven cycle-by-cycle check of fetch_unit (FQ_DEPTH=4,
// ADDR_W=32). Works with or without FETCH_MISALIGN_TRAP_EN defined.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fetch_fault;
`endif

    fetch_unit #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0),
        .FQ_DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    // Instruction memory contents: word at address a holds a + 0x1000_0000
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    // Synchronous instruction memory: data one cycle after the request
    always @(posedge clock) begin
        if (bus.imem_req) bus.imem_rdata <= inst_of(bus.imem_addr);
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic        e_fault;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_ov, input logic [31:0] e_pc, input logic e_fault);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_fault = e_fault;
        vq.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " imem_req"},  bus.imem_req,  32'd0);
        check({tag, " imem_addr"}, bus.imem_addr, 32'h0);
        check({tag, " out_valid"}, bus.out_valid, 32'd0);
        check({tag, " out_inst"},  bus.out_inst,  32'h0);
        check({tag, " out_pc"},    bus.out_pc,    32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check({tag, " fetch_fault"}, fetch_fault, 32'd0);
`endif
    endtask

    // Reset for one cycle, check reset values, release so the next cycle is C0
    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;

        // rst rv rpc rdy | req addr ov pc fault
        // Streaming with out_ready=1
        add(1, 0, 32'h0, 1,  1, 32'h00, 0, 32'h0, 0);
        add(0, 0, 32'h0, 1,  1, 32'h04, 0, 32'h0, 0);
        add(0, 0, 32'h0, 1,  1, 32'h08, 1, 32'h0, 0);
        add(0, 0, 32'h0, 1,  1, 32'h0C, 1, 32'h4, 0);
        add(0, 0, 32'h0, 1,  1, 32'h10, 1, 32'h8, 0);
        add(0, 0, 32'h0, 1,  1, 32'h14, 1, 32'hC, 0);

        // Back-pressure for 10 cycles: exactly four requests, head stable, then drain
        add(1, 0, 32'h0, 0,  1, 32'h00, 0, 32'h0, 0);
        add(0, 0, 32'h0, 0,  1, 32'h04, 0, 32'h0, 0);
        add(0, 0, 32'h0, 0,  1, 32'h08, 1, 32'h0, 0);
        add(0, 0, 32'h0, 0,  1, 32'h0C, 1, 32'h0, 0);
        for (int k = 0; k < 6; k++) add(0, 0, 32'h0, 0,  0, 32'h0, 1, 32'h0, 0);
        add(0, 0, 32'h0, 1,  0, 32'h00, 1, 32'h0,  0);
        add(0, 0, 32'h0, 1,  1, 32'h10, 1, 32'h4,  0);
        add(0, 0, 32'h0, 1,  1, 32'h14, 1, 32'h8,  0);
        add(0, 0, 32'h0, 1,  1, 32'h18, 1, 32'hC,  0);
        add(0, 0, 32'h0, 1,  1, 32'h1C, 1, 32'h10, 0);

        // Redirect to 0x100 with 3 queued + 1 in flight
        add(1, 0, 32'h0,   0,  1, 32'h00,  0, 32'h0,   0);
        add(0, 0, 32'h0,   0,  1, 32'h04,  0, 32'h0,   0);
        add(0, 0, 32'h0,   0,  1, 32'h08,  1, 32'h0,   0);
        add(0, 0, 32'h0,   0,  1, 32'h0C,  1, 32'h0,   0);
        add(0, 1, 32'h100, 0,  0, 32'h0,   0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h100, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h104, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h108, 1, 32'h100, 0);
        add(0, 0, 32'h0,   1,  1, 32'h10C, 1, 32'h104, 0);

        // Redirect coincident with out_valid && out_ready
        add(1, 0, 32'h0,   1,  1, 32'h00,  0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h04,  0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h08,  1, 32'h0,   0);
        add(0, 1, 32'h200, 1,  0, 32'h0,   0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h200, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h204, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h208, 1, 32'h200, 0);
        add(0, 0, 32'h0,   1,  1, 32'h20C, 1, 32'h204, 0);

        // Address wrap past 0xFFFFFFFC
        add(1, 1, 32'hFFFF_FFFC, 1,  0, 32'h0,         0, 32'h0,         0);
        add(0, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 0, 32'h0,         0);
        add(0, 0, 32'h0,         1,  1, 32'h0000_0000, 0, 32'h0,         0);
        add(0, 0, 32'h0,         1,  1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 0);
        add(0, 0, 32'h0,         1,  1, 32'h0000_0008, 1, 32'h0000_0000, 0);

        // Misaligned redirect to 0x102
        add(1, 0, 32'h0,   1,  1, 32'h00,  0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h04,  0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h08,  1, 32'h0,   0);
        add(0, 1, 32'h102, 1,  0, 32'h0,   0, 32'h0,   0);
`ifdef FETCH_MISALIGN_TRAP_EN
        add(0, 0, 32'h0,   1,  0, 32'h0,   0, 32'h0,   1);
        add(0, 0, 32'h0,   1,  0, 32'h0,   0, 32'h0,   1);
        add(0, 0, 32'h0,   1,  0, 32'h0,   0, 32'h0,   1);
        add(0, 1, 32'h200, 1,  0, 32'h0,   0, 32'h0,   1);
        add(0, 0, 32'h0,   1,  1, 32'h200, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h204, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h208, 1, 32'h200, 0);
`else
        add(0, 0, 32'h0,   1,  1, 32'h100, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h104, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1,  1, 32'h108, 1, 32'h100, 0);
        add(0, 0, 32'h0,   1,  1, 32'h10C, 1, 32'h104, 0);
`endif

        foreach (vq[i]) begin
            if (vq[i].rst) do_reset();
            bus.redirect_valid = vq[i].rv;
            bus.redirect_pc    = vq[i].rpc;
            bus.out_ready      = vq[i].rdy;
            @(negedge clock);
            check($sformatf("row%0d imem_req", i), bus.imem_req, vq[i].e_req);
            if (vq[i].e_req) check($sformatf("row%0d imem_addr", i), bus.imem_addr, vq[i].e_addr);
            check($sformatf("row%0d out_valid", i), bus.out_valid, vq[i].e_ov);
            if (vq[i].e_ov) begin
                check($sformatf("row%0d out_pc", i),   bus.out_pc,   vq[i].e_pc);
                check($sformatf("row%0d out_inst", i), bus.out_inst, inst_of(vq[i].e_pc));
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            check($sformatf("row%0d fetch_fault", i), fetch_fault, vq[i].e_fault);
`endif
            @(posedge clock);
            #1;
        end

        // Asynchronous reset in the middle of streaming
        do_reset();
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #3;
        check("midrst pre out_valid", bus.out_valid, 32'd1);
        check("midrst pre out_pc",    bus.out_pc,    32'h8);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("restart imem_req",  bus.imem_req,  32'd1);
        check("restart imem_addr", bus.imem_addr, 32'h0);
        check("restart out_valid", bus.out_valid, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
